// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbitration path.
// Imported by rr_pick and rr_grant_controller.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Next index modulo n by compare-and-wrap, so non-power-of-2 n works.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating first-one finder: searches req starting at ptr+1,
// wrapping modulo N, and reports the first set index.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'(wrap_inc(32'(idx), N));
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/rr_grant_controller.sv
// Round-robin req/rel grant sequencer with registered one-hot grant.
// Optional forced revoke after MAX_HOLD cycles when RR_TIMEOUT_EN is defined.
module rr_grant_controller
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              rel,
  output logic [N_REQ-1:0]              gnt,
  output logic [id_width(N_REQ)-1:0]    gnt_id,
  output logic                          gnt_valid,
  output logic                          timeout,
  output logic [id_width(N_REQ)-1:0]    timeout_id
);

  localparam int unsigned IW = id_width(N_REQ);

  if (N_REQ < 2 || MAX_HOLD < 2) begin : g_bad_params
    $error("rr_grant_controller: N_REQ and MAX_HOLD must both be >= 2");
  end

  rr_state_t        state, state_n;
  logic [IW-1:0]    ptr, ptr_n, id_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IW-1:0]    win;
  logic             any;
  logic             released;
  logic             expire;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // Only the owner's rel counts; the owner dropping req is an implicit release.
  assign released  = rel[gnt_id] | ~req[gnt_id];
  assign gnt_valid = |gnt;

`ifdef RR_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt;

  assign expire = (hold_cnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt   <= '0;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      hold_cnt   <= (state == GRANT) ? hold_cnt + HW'(1) : '0;
      timeout    <= (state == GRANT) && !released && expire;
      timeout_id <= ((state == GRANT) && !released && expire) ? gnt_id : '0;
    end
  end
`else
  assign expire     = 1'b0;
  assign timeout    = 1'b0;
  assign timeout_id = '0;
`endif

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n    = GRANT;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          id_n       = win;
        end
      end
      GRANT: begin
        // A revoke is the same transition as a release; release wins the pulse.
        if (released || expire) begin
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = gnt_id;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= IW'(N_REQ - 1);
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      gnt_id <= id_n;
      ptr    <= ptr_n;
    end
  end

endmodule

// File: tb/tb_rr_grant_controller.sv
// Self-checking bench for rr_grant_controller (N_REQ=4 and N_REQ=5, MAX_HOLD=4).
// Expectations come from a per-cycle ownership model plus directed constants.
module tb_rr_grant_controller;

  localparam int MH = 4;
`ifdef RR_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0] req4 = '0, rel4 = '0, gnt4;
  logic [1:0] id4, toid4;
  logic       vld4, to4;
  logic [4:0] req5 = '0, rel5 = '0, gnt5;
  logic [2:0] id5, toid5;
  logic       vld5, to5;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_grant_controller #(.N_REQ(4), .MAX_HOLD(MH)) u4 (
    .clk(clk), .rst(rst), .req(req4), .rel(rel4), .gnt(gnt4), .gnt_id(id4),
    .gnt_valid(vld4), .timeout(to4), .timeout_id(toid4)
  );

  rr_grant_controller #(.N_REQ(5), .MAX_HOLD(MH)) u5 (
    .clk(clk), .rst(rst), .req(req5), .rel(rel5), .gnt(gnt5), .gnt_id(id5),
    .gnt_valid(vld5), .timeout(to5), .timeout_id(toid5)
  );

  // Reference: who owns the resource, who owned it last, how long it has been held.
  typedef struct {
    int owner;
    int last;
    int gid;
    int held;
    bit to;
    int to_id;
  } mdl_t;

  mdl_t m4, m5;

  function automatic mdl_t mdl_reset(int n);
    mdl_t r;
    r.owner = -1; r.last = n - 1; r.gid = 0; r.held = 0; r.to = 1'b0; r.to_id = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int n, logic [7:0] rq, logic [7:0] rl);
    mdl_t r = m;
    bit found = 1'b0;
    r.to = 1'b0;
    r.to_id = 0;
    if (m.owner >= 0) begin
      if (rl[m.owner] || !rq[m.owner]) begin
        r.last = m.owner; r.owner = -1;
      end else if (TMO && m.held == MH) begin
        r.last = m.owner; r.owner = -1; r.to = 1'b1; r.to_id = m.owner;
      end else begin
        r.held = m.held + 1;
      end
    end else begin
      for (int k = 1; k <= n; k++) begin
        int c = (m.last + k) % n;
        if (!found && rq[c]) begin
          found = 1'b1; r.owner = c; r.gid = c; r.held = 1;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4 <= mdl_reset(4);
      m5 <= mdl_reset(5);
    end else begin
      m4 <= mdl_step(m4, 4, {4'b0, req4}, {4'b0, rel4});
      m5 <= mdl_step(m5, 5, {3'b0, req5}, {3'b0, rel5});
    end
  end

  function automatic logic [9:0] exp4();
    logic [3:0] g;
    g = (m4.owner >= 0) ? 4'(1 << m4.owner) : 4'b0;
    return {g, 2'(m4.gid), |g, m4.to, 2'(m4.to_id)};
  endfunction

  function automatic logic [12:0] exp5();
    logic [4:0] g;
    g = (m5.owner >= 0) ? 5'(1 << m5.owner) : 5'b0;
    return {g, 3'(m5.gid), |g, m5.to, 3'(m5.to_id)};
  endfunction

  logic [9:0]  obs4;
  logic [12:0] obs5;
  assign obs4 = {gnt4, id4, vld4, to4, toid4};
  assign obs5 = {gnt5, id5, vld5, to5, toid5};

  task automatic test_reset();
    rst = 1'b1; req4 = '0; rel4 = '0; req5 = '0; rel5 = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs4 !== 10'b0) begin n_fail++; $display("FAIL reset4: got %b expected %b", obs4, 10'b0); end
    n_chk++;
    if (obs5 !== 13'b0) begin n_fail++; $display("FAIL reset5: got %b expected %b", obs5, 13'b0); end
    rst = 1'b0;
    @(negedge clk); req4 = 4'b0001;
    @(negedge clk);
    n_chk++;
    if ({gnt4, id4, vld4} !== 7'b0001_00_1) begin
      n_fail++; $display("FAIL first_grant: got %b expected %b", {gnt4, id4, vld4}, 7'b0001_00_1);
    end
    n_chk++;
    if (obs4 !== exp4()) begin n_fail++; $display("FAIL first_grant_model: got %b expected %b", obs4, exp4()); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({gnt4, vld4} !== 5'b0) begin n_fail++; $display("FAIL async_reset: got %b expected %b", {gnt4, vld4}, 5'b0); end
    n_chk++;
    if (obs4 !== exp4()) begin n_fail++; $display("FAIL async_reset_model: got %b expected %b", obs4, exp4()); end
    @(negedge clk); rst = 1'b0; req4 = '0;
    @(negedge clk);
    n_chk++;
    if (obs4 !== exp4()) begin n_fail++; $display("FAIL post_reset_idle: got %b expected %b", obs4, exp4()); end
  endtask

  task automatic test_rotation();
    req4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (gnt4 !== 4'(1 << (k % 4))) begin
        n_fail++; $display("FAIL rotation_order[%0d]: got %b expected %b", k, gnt4, 4'(1 << (k % 4)));
      end
      n_chk++;
      if (obs4 !== exp4()) begin n_fail++; $display("FAIL rotation_grant_model: got %b expected %b", obs4, exp4()); end
      @(negedge clk);
      n_chk++;
      if (obs4 !== exp4()) begin n_fail++; $display("FAIL rotation_hold_model: got %b expected %b", obs4, exp4()); end
      rel4 = gnt4;
      @(negedge clk);
      rel4 = '0;
      if (k == 4) req4 = '0;
      n_chk++;
      if (gnt4 !== 4'b0000) begin n_fail++; $display("FAIL rotation_dead[%0d]: got %b expected 0000", k, gnt4); end
    end
    @(negedge clk);
    n_chk++;
    if (obs4 !== exp4()) begin n_fail++; $display("FAIL rotation_idle_model: got %b expected %b", obs4, exp4()); end
  endtask

  task automatic test_skip_wrap();
    req4 = 4'b0100;
    @(negedge clk);
    n_chk++;
    if ({gnt4, id4} !== 6'b0100_10) begin n_fail++; $display("FAIL set_last2: got %b expected %b", {gnt4, id4}, 6'b0100_10); end
    req4 = '0;
    @(negedge clk);
    n_chk++;
    if (obs4 !== exp4()) begin n_fail++; $display("FAIL skip_release_model: got %b expected %b", obs4, exp4()); end
    req4 = 4'b0101;
    @(negedge clk);
    n_chk++;
    if ({gnt4, id4} !== 6'b0001_00) begin n_fail++; $display("FAIL skip_wrap: got %b expected %b", {gnt4, id4}, 6'b0001_00); end
    req4 = '0;
    @(negedge clk);
    req4 = 4'b0100;
    @(negedge clk);
    n_chk++;
    if ({gnt4, id4} !== 6'b0100_10) begin n_fail++; $display("FAIL only_two: got %b expected %b", {gnt4, id4}, 6'b0100_10); end
    req4 = '0;
    @(negedge clk);
    n_chk++;
    if (obs4 !== exp4()) begin n_fail++; $display("FAIL skip_idle_model: got %b expected %b", obs4, exp4()); end
  endtask

  task automatic test_rel_ignore();
    req4 = 4'b0010;
    @(negedge clk);
    n_chk++;
    if (gnt4 !== 4'b0010) begin n_fail++; $display("FAIL grant1: got %b expected 0010", gnt4); end
    rel4 = 4'b1000;
    @(negedge clk);
    rel4 = '0;
    n_chk++;
    if (gnt4 !== 4'b0010) begin n_fail++; $display("FAIL foreign_rel_held: got %b expected 0010", gnt4); end
    req4 = 4'b1010; rel4 = 4'b1010;
    @(negedge clk);
    rel4 = '0; req4 = 4'b1000;
    n_chk++;
    if (gnt4 !== 4'b0000) begin n_fail++; $display("FAIL rel_dead: got %b expected 0000", gnt4); end
    @(negedge clk);
    n_chk++;
    if ({gnt4, id4} !== 6'b1000_11) begin n_fail++; $display("FAIL rel_next: got %b expected %b", {gnt4, id4}, 6'b1000_11); end
    req4 = '0;
    @(negedge clk);
    n_chk++;
    if (obs4 !== exp4()) begin n_fail++; $display("FAIL rel_idle_model: got %b expected %b", obs4, exp4()); end
  endtask

  task automatic test_drop_wrap();
    req5 = 5'b10000;
    @(negedge clk);
    n_chk++;
    if ({gnt5, id5} !== 8'b10000_100) begin n_fail++; $display("FAIL grant4_n5: got %b expected %b", {gnt5, id5}, 8'b10000_100); end
    req5 = '0;
    @(negedge clk);
    n_chk++;
    if (gnt5 !== 5'b0) begin n_fail++; $display("FAIL drop_release_n5: got %b expected 00000", gnt5); end
    req5 = 5'b11111;
    @(negedge clk);
    n_chk++;
    if ({gnt5, id5} !== 8'b00001_000) begin n_fail++; $display("FAIL wrap_n5: got %b expected %b", {gnt5, id5}, 8'b00001_000); end
    req5 = 5'b11110;
    @(negedge clk);
    n_chk++;
    if (obs5 !== exp5()) begin n_fail++; $display("FAIL drop_dead_model_n5: got %b expected %b", obs5, exp5()); end
    @(negedge clk);
    n_chk++;
    if ({gnt5, id5} !== 8'b00010_001) begin n_fail++; $display("FAIL drop_advance_n5: got %b expected %b", {gnt5, id5}, 8'b00010_001); end
    req5 = '0;
    @(negedge clk);
    n_chk++;
    if (obs5 !== exp5()) begin n_fail++; $display("FAIL drop_idle_model_n5: got %b expected %b", obs5, exp5()); end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit saw_to = 1'b0;
    req4 = 4'b0110;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs4 !== exp4()) begin n_fail++; $display("FAIL timeout_model: got %b expected %b", obs4, exp4()); end
      if (to4) saw_to = 1'b1;
      if (gnt4 == 4'b0010) cnt++;
      else break;
    end
`ifdef RR_TIMEOUT_EN
    n_chk++;
    if (cnt !== MH) begin n_fail++; $display("FAIL hold_cycles: got %0d expected %0d", cnt, MH); end
    n_chk++;
    if ({gnt4, to4, toid4} !== 7'b0000_1_01) begin
      n_fail++; $display("FAIL timeout_pulse: got %b expected %b", {gnt4, to4, toid4}, 7'b0000_1_01);
    end
    @(negedge clk);
    n_chk++;
    if ({gnt4, id4, to4} !== 7'b0100_10_0) begin
      n_fail++; $display("FAIL after_timeout: got %b expected %b", {gnt4, id4, to4}, 7'b0100_10_0);
    end
`else
    n_chk++;
    if (cnt !== 100) begin n_fail++; $display("FAIL hold_forever: got %0d expected 100", cnt); end
    n_chk++;
    if (saw_to !== 1'b0) begin n_fail++; $display("FAIL timeout_tied: got %b expected 0", saw_to); end
`endif
    req4 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req4 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req5 = 5'($urandom);
      rel4 = ($urandom_range(0, 3) == 0) ? gnt4 : (4'($urandom) & 4'($urandom) & 4'($urandom));
      rel5 = ($urandom_range(0, 3) == 0) ? gnt5 : (5'($urandom) & 5'($urandom) & 5'($urandom));
      @(negedge clk);
      n_chk++;
      if (obs4 !== exp4()) begin n_fail++; $display("FAIL random4[%0d]: got %b expected %b", i, obs4, exp4()); end
      n_chk++;
      if (obs5 !== exp5()) begin n_fail++; $display("FAIL random5[%0d]: got %b expected %b", i, obs5, exp5()); end
    end
    req4 = '0; rel4 = '0; req5 = '0; rel5 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_rel_ignore();
    test_drop_wrap();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
